// File: rtl/bound_flasher_ctrl.sv
// ---------------------------------------------------------------------------
// bound_flasher_ctrl
//
// Sequencing controller for the 16-lamp bound flasher. It holds the state
// code that drives the led_behavior decoder, and the lamp count (number of
// lit lamps, 0..16) that forms the LED datapath. Once started by flick, the
// lamps walk one position per step tick through the fixed pattern
//   0->16, 16->5, 5->11, 11->0, 0->6, 6->0
// with flick kickbacks in the two rising legs that start toward 16 and 11.
//
// Parameters
//   STEP_DIV : clock cycles per lamp step (>= 1); 1 = one step per clock
//   DIV_W    : prescaler width, derived from STEP_DIV (leave at default)
//
// Ports
//   clk     in   1   system clock, all state updates on the rising edge
//   rst_n   in   1   asynchronous active-low reset
//   flick   in   1   start / kickback request, level-sampled
//   cur_st  out  3   state code (0 INITIAL, 1 0_TO_15, 2 15_TO_5, 3 5_TO_10,
//                    4 10_TO_0, 5 0_TO_5, 6 5_TO_0)
//   led     out  16  thermometer lamp outputs, led[i] = 1 iff i < lamp count
//   busy    out  1   high whenever cur_st is not INITIAL
// ---------------------------------------------------------------------------
module bound_flasher_ctrl #(
    parameter int STEP_DIV = 1,
    parameter int DIV_W    = $clog2(STEP_DIV + 1)
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        flick,
    output logic [2:0]  cur_st,
    output logic [15:0] led,
    output logic        busy
);

    // State codes are shared with led_behavior and must not be renumbered.
    typedef enum logic [2:0] {
        ST_INIT = 3'd0,   // idle, all lamps off
        ST_UP16 = 3'd1,   // 0_TO_15  : light lamps up to all 16
        ST_DN5  = 3'd2,   // 15_TO_5  : turn off down to 5 lit
        ST_UP11 = 3'd3,   // 5_TO_10  : light up to 11 lit
        ST_DN0K = 3'd4,   // 10_TO_0  : turn all off (kickback landing leg)
        ST_UP6  = 3'd5,   // 0_TO_5   : light up to 6 lit
        ST_DN0  = 3'd6    // 5_TO_0   : turn all off, back to idle
    } state_t;

    localparam logic [DIV_W-1:0] DIV_LAST = DIV_W'(STEP_DIV - 1);

    state_t           state_q, state_d;
    logic [4:0]       cnt_q,   cnt_d;
    logic [DIV_W-1:0] div_q,   div_d;
    logic             kick_q,  kick_d;

    logic             tick;
    logic             at_target;
    logic             kick_up16;
    logic             kick_up11;

    // Lamp count at which a leg ends and the sequence moves on.
    function automatic logic [4:0] target_of(input state_t s);
        case (s)
            ST_UP16: target_of = 5'd16;
            ST_DN5:  target_of = 5'd5;
            ST_UP11: target_of = 5'd11;
            ST_UP6:  target_of = 5'd6;
            default: target_of = 5'd0;
        endcase
    endfunction

    // Rising legs light one more lamp per tick; the others turn one off.
    function automatic logic is_up(input state_t s);
        is_up = (s == ST_UP16) || (s == ST_UP11) || (s == ST_UP6);
    endfunction

    // Successor leg once the target count is reached. The 10_TO_0 leg
    // returns to the start when it was entered through a kickback.
    function automatic state_t next_of(input state_t s, input logic k);
        case (s)
            ST_UP16: next_of = ST_DN5;
            ST_DN5:  next_of = ST_UP11;
            ST_UP11: next_of = ST_DN0K;
            ST_DN0K: next_of = k ? ST_UP16 : ST_UP6;
            ST_UP6:  next_of = ST_DN0;
            default: next_of = ST_INIT;
        endcase
    endfunction

    assign busy      = (state_q != ST_INIT);
    assign tick      = busy && (div_q == DIV_LAST);
    assign at_target = (cnt_q == target_of(state_q));

    // Kickback requests, only honoured on a tick. They outrank both the
    // step and the normal leg exit.
    assign kick_up16 = flick && (state_q == ST_UP16) &&
                       ((cnt_q == 5'd6) || (cnt_q == 5'd11));
    assign kick_up11 = flick && (state_q == ST_UP11) && (cnt_q == 5'd11);

    // State register
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= ST_INIT;
            cnt_q   <= 5'd0;
            div_q   <= '0;
            kick_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            div_q   <= div_d;
            kick_q  <= kick_d;
        end
    end

    // Next-state and datapath update
    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        div_d   = div_q;
        kick_d  = kick_q;

        if (state_q == ST_INIT) begin
            // Idle: prescaler parked so the first step lands a full
            // STEP_DIV cycles after the start edge.
            div_d = '0;
            cnt_d = 5'd0;
            if (flick) begin
                state_d = ST_UP16;
            end
        end else begin
            div_d = (div_q == DIV_LAST) ? '0 : div_q + DIV_W'(1);

            // A tick either moves the lamp count or changes leg, never both.
            if (tick) begin
                if (kick_up16) begin
                    state_d = ST_DN0K;
                    kick_d  = 1'b1;
                end else if (kick_up11) begin
                    state_d = ST_DN5;
                end else if (at_target) begin
                    state_d = next_of(state_q, kick_q);
                    if (state_q == ST_DN0K) begin
                        kick_d = 1'b0;
                    end
                end else if (is_up(state_q)) begin
                    cnt_d = cnt_q + 5'd1;
                end else begin
                    cnt_d = cnt_q - 5'd1;
                end
            end
        end
    end

    // Thermometer decode of the lamp count.
    always_comb begin
        led = '0;
        for (int i = 0; i < 16; i++) begin
            led[i] = (5'(i) < cnt_q);
        end
    end

    assign cur_st = state_q;

endmodule

// File: tb/tb_bound_flasher_ctrl.sv
// ---------------------------------------------------------------------------
// tb_bound_flasher_ctrl
//
// Runs two controllers side by side from one flick/reset stream: one with
// STEP_DIV=1 and one with STEP_DIV=4. A reference model describes the lamp
// program as a table of legs (target count and following leg) and steps it
// every clock; its expected outputs go into per-instance queues and a
// separate monitor pops and compares them against the DUT outputs on the
// falling edge. Directed phases cover the start-up, full runs, kickbacks,
// non-tick flicks and asynchronous reset; a random phase follows.
// ---------------------------------------------------------------------------
module tb_bound_flasher_ctrl;

    logic        clk   = 1'b0;
    logic        rst_n = 1'b1;
    logic        flick = 1'b0;

    logic [2:0]  st0, st1;
    logic [15:0] led0, led1;
    logic        busy0, busy1;

    bound_flasher_ctrl #(.STEP_DIV(1)) u_dut0 (
        .clk    (clk),
        .rst_n  (rst_n),
        .flick  (flick),
        .cur_st (st0),
        .led    (led0),
        .busy   (busy0)
    );

    bound_flasher_ctrl #(.STEP_DIV(4)) u_dut1 (
        .clk    (clk),
        .rst_n  (rst_n),
        .flick  (flick),
        .cur_st (st1),
        .led    (led1),
        .busy   (busy1)
    );

    always #5 clk = ~clk;

    int total = 0;
    int bad   = 0;

    // ---------------- reference model ----------------
    typedef logic [19:0] obs_t;   // {cur_st, led, busy}

    int divs [0:1] = '{1, 4};
    // Leg table indexed by state code: lamp count ending the leg, next leg.
    int tgt  [0:6] = '{0, 16, 5, 11, 0, 6, 0};
    int nxt  [0:6] = '{0, 2, 3, 4, 5, 6, 0};

    int m_st   [0:1] = '{0, 0};
    int m_cnt  [0:1] = '{0, 0};
    int m_div  [0:1] = '{0, 0};
    bit m_kick [0:1] = '{0, 0};

    obs_t q0[$];
    obs_t q1[$];

    function automatic obs_t expect_of(input int i);
        logic [15:0] l;
        l = 16'((32'h1 << m_cnt[i]) - 32'h1);
        return {3'(m_st[i]), l, (m_st[i] != 0)};
    endfunction

    task automatic mreset();
        for (int i = 0; i < 2; i++) begin
            m_st[i] = 0; m_cnt[i] = 0; m_div[i] = 0; m_kick[i] = 0;
        end
    endtask

    task automatic mstep(input int i, input bit f);
        bit tk;
        if (m_st[i] == 0) begin
            if (f) begin
                m_st[i]  = 1;
                m_div[i] = 0;
            end
            return;
        end
        tk       = (m_div[i] == divs[i] - 1);
        m_div[i] = (m_div[i] + 1) % divs[i];
        if (!tk) return;
        if (f && m_st[i] == 1 && (m_cnt[i] == 6 || m_cnt[i] == 11)) begin
            m_st[i]   = 4;
            m_kick[i] = 1;
        end else if (f && m_st[i] == 3 && m_cnt[i] == 11) begin
            m_st[i] = 2;
        end else if (m_cnt[i] == tgt[m_st[i]]) begin
            if (m_st[i] == 4) begin
                m_st[i]   = m_kick[i] ? 1 : 5;
                m_kick[i] = 0;
            end else begin
                m_st[i] = nxt[m_st[i]];
            end
        end else begin
            m_cnt[i] += (m_st[i] % 2 == 1) ? 1 : -1;
        end
    endtask

    always @(posedge clk or negedge rst_n) begin
        if (!rst_n) mreset();
        else begin
            mstep(0, flick);
            mstep(1, flick);
        end
    end

    // Expected outputs for this cycle enter the scoreboard.
    always @(negedge clk) begin
        q0.push_back(expect_of(0));
        q1.push_back(expect_of(1));
    end

    // ---------------- monitor ----------------
    always @(negedge clk) begin
        obs_t e;
        obs_t a;
        bit   have;
        #1;
        for (int i = 0; i < 2; i++) begin
            if (i == 0) begin
                a    = {st0, led0, busy0};
                have = (q0.size() > 0);
                if (have) e = q0.pop_front();
            end else begin
                a    = {st1, led1, busy1};
                have = (q1.size() > 0);
                if (have) e = q1.pop_front();
            end
            total++;
            if (!have) begin
                bad++;
                $display("FAIL sb%0d_empty t=%0t actual st=%0d led=%h busy=%b required=queued entry",
                         i, $time, a[19:17], a[16:1], a[0]);
            end else if (a !== e) begin
                bad++;
                $display("FAIL out%0d t=%0t actual st=%0d led=%h busy=%b required st=%0d led=%h busy=%b",
                         i, $time, a[19:17], a[16:1], a[0], e[19:17], e[16:1], e[0]);
            end
        end
    end

    // ---------------- stimulus ----------------
    task automatic cyc(input int n);
        repeat (n) begin
            @(negedge clk);
            #2;
        end
    endtask

    task automatic pulse();
        flick = 1'b1;
        cyc(1);
        flick = 1'b0;
    endtask

    task automatic wait_for(input int i, input int st, input int cnt, input int budget, input string tag);
        int c;
        c = 0;
        while (!(m_st[i] == st && m_cnt[i] == cnt) && c < budget) begin
            cyc(1);
            c++;
        end
        if (c >= budget) begin
            total++;
            bad++;
            $display("FAIL wait_%s actual=timeout after %0d cycles required st=%0d cnt=%0d", tag, c, st, cnt);
        end
    endtask

    task automatic wait_idle(input int budget, input string tag);
        int c;
        c = 0;
        while ((m_st[0] != 0 || m_st[1] != 0) && c < budget) begin
            cyc(1);
            c++;
        end
        if (c >= budget) begin
            total++;
            bad++;
            $display("FAIL idle_%s actual=timeout after %0d cycles required=both idle", tag, c);
        end
    endtask

    initial begin
        int n0, n1, c;

        // Reset asserted with flick high, then released with flick low.
        #1;
        rst_n = 1'b0;
        flick = 1'b1;
        @(negedge clk);
        #2;
        cyc(3);
        rst_n = 1'b1;
        flick = 1'b0;
        cyc(100);

        // Full unkicked run; measure busy length of both instances.
        flick = 1'b1;
        cyc(1);
        flick = 1'b0;
        n0 = 0; n1 = 0; c = 0;
        while ((busy0 || busy1) && c < 400) begin
            n0 += int'(busy0);
            n1 += int'(busy1);
            cyc(1);
            c++;
        end
        total++;
        if (n0 != 62) begin
            bad++;
            $display("FAIL runlen_div1 actual=%0d required=62", n0);
        end
        total++;
        if (n1 != 248) begin
            bad++;
            $display("FAIL runlen_div4 actual=%0d required=248", n1);
        end
        cyc(3);

        // Kickbacks in the first rising leg, at 6 lit and at 11 lit.
        pulse();
        wait_for(0, 1, 6, 50, "k1_6");
        pulse();
        wait_for(0, 1, 11, 100, "k1_11");
        pulse();
        wait_idle(2000, "k1");

        // Kickback in the 5_TO_10 leg, then a normal exit.
        pulse();
        wait_for(0, 3, 11, 200, "k3_a");
        pulse();
        wait_for(0, 3, 11, 200, "k3_b");
        cyc(2);
        wait_idle(2000, "k3");

        // Slow instance: flick on a non-tick cycle, then on a tick cycle.
        pulse();
        wait_for(1, 1, 6, 100, "nt_6");
        c = 0;
        while (m_div[1] == 3 && c < 8) begin cyc(1); c++; end
        pulse();
        wait_for(1, 1, 11, 100, "t_11");
        c = 0;
        while (m_div[1] != 3 && c < 8) begin cyc(1); c++; end
        pulse();
        wait_idle(2000, "div4");

        // flick held through the return to idle restarts immediately.
        pulse();
        wait_for(0, 6, 3, 200, "hold6");
        flick = 1'b1;
        wait_for(0, 0, 0, 20, "hold0");
        wait_for(0, 1, 0, 5, "hold1");
        flick = 1'b0;
        wait_idle(3000, "hold");

        // Asynchronous reset in the middle of the 5_TO_10 leg.
        pulse();
        wait_for(0, 3, 9, 200, "rst_mid");
        @(posedge clk);
        #2;
        rst_n = 1'b0;
        #1;
        total++;
        if ({st0, led0, busy0} !== 20'h0) begin
            bad++;
            $display("FAIL async_rst actual st=%0d led=%h busy=%b required st=0 led=0000 busy=0",
                     st0, led0, busy0);
        end
        @(negedge clk);
        #2;
        cyc(1);
        rst_n = 1'b1;
        cyc(3);
        pulse();
        wait_idle(1000, "post_rst");

        // Random flick stream with occasional mid-cycle resets.
        for (int k = 0; k < 2500; k++) begin
            flick = ($urandom_range(0, 7) == 0);
            if ($urandom_range(0, 399) == 0) begin
                @(posedge clk);
                #3;
                rst_n = 1'b0;
                @(negedge clk);
                #2;
                rst_n = 1'b1;
            end else begin
                cyc(1);
            end
        end
        flick = 1'b0;
        cyc(3);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/bound_flasher_ctrl.md
Name: bound_flasher_ctrl

Overview:
Sequencing controller for the 16-lamp bound flasher. It owns the state register whose code drives the led_behavior decoder, and the lamp thermometer counter that forms the LED datapath. It steps the lamps one position per step tick through the fixed on/off pattern and applies the flick kickback rules. It sits between the flick input pin and the 16 lamp outputs.

Parameters:
STEP_DIV, 1, clock cycles per lamp step (>=1); 1 = one step per clock
DIV_W, $clog2(STEP_DIV+1), width of prescaler counter (derived, do not override)

Ports:
clk  in  1  system clock, all state on rising edge
rst_n  in  1  asynchronous active-low reset
flick  in  1  start / kickback request, level-sampled
cur_st  out  3  state code (0 INITIAL, 1 0_TO_15, 2 15_TO_5, 3 5_TO_10, 4 10_TO_0, 5 0_TO_5, 6 5_TO_0); codes match led_behavior
led  out  16  lamp outputs, thermometer code: led[i]=1 iff i<cnt
busy  out  1  1 when cur_st != INITIAL

Behaviour:
- Reset (rst_n=0, async): cur_st=0, cnt=0, led=16'h0000, busy=0, div_cnt=0, kick=0. Reset mid-sequence aborts immediately; no step completes.
- Internal: cnt[4:0] in 0..16 = number of lit lamps; led is a registered/combinational decode of cnt (led=(1<<cnt)-1); kick 1-bit flag; code 7 is never produced.
- Prescaler: div_cnt held at 0 in INITIAL; otherwise counts 0..STEP_DIV-1 and wraps. tick = busy && div_cnt==STEP_DIV-1. STEP_DIV=1 -> tick every busy cycle.
- INITIAL: cnt=0. flick=1 on any clock edge -> cur_st=1 next cycle, div_cnt=0. flick=0 -> stay.
- All other transitions and cnt changes occur only on tick. A tick either changes cnt by one or changes state, never both.
- Up states (1, 3, 5): tick with cnt<target -> cnt+1; cnt==target -> next state. Targets: 1:16, 3:11, 5:6.
- Down states (2, 4, 6): tick with cnt>target -> cnt-1; cnt==target -> next state. Targets: 2:5, 4:0, 6:0.
- Next state on target: 1->2, 2->3, 3->4, 4->(kick ? 1 : 5), 6->0. Leaving 4 clears kick.
- Kickback, state 1: tick with (cnt==6 or cnt==11) and flick=1 -> cur_st=4, kick=1, cnt unchanged. Lamps then turn off to 0, and the sequence restarts at state 1. Kickback has priority over increment.
- Kickback, state 3: tick with cnt==11 and flick=1 -> cur_st=2, cnt unchanged. Lamps turn off to 5 again, then state 3 repeats. Takes priority over the normal 3->4 exit.
- flick is ignored in states 2, 4, 5, 6 and on non-tick cycles. Repeated kickbacks are unlimited.
- flick held high through the return to INITIAL restarts state 1 on the next edge.
- Nominal sequence length with STEP_DIV=1 and no kickback is 62 ticks after entering state 1: 17+12+7+12+7+7.

Test Plan:
- Reset: rst_n=0 with flick=1 -> cur_st=0, led=0000, busy=0. Release with flick=0 -> stays idle for 100 cycles.
- Full run, STEP_DIV=1: 1-cycle flick pulse -> cur_st=1 next cycle. led reaches FFFF at tick 16; cur_st=2 at tick 17; led=001F before state 3; led=07FF before state 4; led=003F before state 6. cur_st=0 at tick 62 with led=0000.
- Kickback in state 1: flick=1 while led=003F -> cur_st=4, led decrements to 0000, then cur_st=1 (not 5), kick cleared. Second kick at led=07FF behaves identically.
- Kickback in state 3: flick=1 when led=07FF -> cur_st=2, led falls to 001F, then cur_st=3 again. flick=0 next time -> exits to state 4.
- STEP_DIV=4: the same full run takes 248 cycles from entering state 1. led changes only every 4th cycle. flick pulse on a non-tick cycle during state 1 -> no kickback.
- Async reset mid-run: rst_n low during state 3 with led=01FF, asserted between clock edges -> led=0000 and cur_st=0 immediately. After release, a flick restarts from state 1 with cnt=0.
